mem_mpu_region: RTL and testbench

Parametrised memory protection unit between the picorv32 native memory interface and the on-chip word-addressed SRAM. At reset, and on a software `reload` pulse, it loads a region table from SRAM into internal registers. It then checks every in-range access against that table. Instruction fetches need an execute-permitted address region. Data accesses need both a matching PC range and a data range with the right R/W permission. A denied access completes with zero read data and a suppressed write, and raises a sticky interrupt with captured fault information.

---
 rtl/mem_mpu_region_if.sv | 28 ++
 rtl/mem_mpu_region.sv | 197 +++++++++++++++++++
 tb/tb_mem_mpu_region.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_mpu_region_if.sv
// CPU-side native memory bus and SRAM-side port of the MPU, bundled for drop-in wiring.
// master = CPU/SRAM environment, slave = the MPU itself.
interface mem_mpu_region_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  cpu_valid;
    logic                  cpu_instr;
    logic [31:0]           cpu_pc;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [3:0]            cpu_wstrb;
    logic                  cpu_ready;
    logic [31:0]           cpu_rdata;
    logic [3:0]            mem_wen;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output cpu_valid, cpu_instr, cpu_pc, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        input  cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_valid, cpu_instr, cpu_pc, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
        output cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_mpu_region.sv
// Region-table MPU between picorv32 and word-addressed SRAM: loads its table from SRAM,
// then allows or faults each in-range access, raising a sticky irq with fault details.
module mem_mpu_region #(
    parameter int MEM_WORDS     = 1024,
    parameter int ADDR_WIDTH    = 22,
    parameter int MPU_REGIONS   = 4,
    parameter int MPU_BASE_WORD = 768,
    parameter int ENTRY_WORDS   = 5
) (
    input  logic               clk,
    input  logic               resetn,
    mem_mpu_region_if.slave    bus,
    input  logic               reload,
    input  logic               irq_ack,
    output logic               busy,
    output logic               irq,
    output logic [31:0]        fault_addr,
    output logic [31:0]        fault_pc,
    output logic [1:0]         fault_type,
    output logic               fault_overrun
);
    localparam int unsigned NWORDS = ENTRY_WORDS * MPU_REGIONS;
    localparam int          CW     = $clog2(NWORDS);
    localparam logic [CW-1:0]         LAST   = CW'(NWORDS - 1);
    localparam logic [ADDR_WIDTH-3:0] BASE_W = (ADDR_WIDTH-2)'(MPU_BASE_WORD);
    localparam logic [31:0]           LIMIT  = 32'(4 * MEM_WORDS);

    localparam logic [2:0] S_LOAD_ADDR = 3'd0;
    localparam logic [2:0] S_LOAD_DATA = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_ACCESS    = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_FAULT     = 3'd7;

    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [31:0]           r_tab [NWORDS];
    logic                  r_busy;
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic [3:0]            r_wen;
    logic [ADDR_WIDTH-3:0] r_maddr;
    logic [31:0]           r_mwdata;
    logic                  r_instr;
    logic [31:0]           r_pc;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_reload_pend;
    logic                  r_irq;
    logic [31:0]           r_faddr;
    logic [31:0]           r_fpc;
    logic [1:0]            r_ftype;
    logic                  r_over;

    logic [31:0]            w_cpu_addr;
    logic [CW-1:0]          w_cnt_nxt;
    logic [MPU_REGIONS-1:0] w_cov;
    logic [MPU_REGIONS-1:0] w_ok;
    logic                   w_match;
    logic                   w_cover;
    logic [1:0]             w_ftype;

    assign w_cpu_addr = 32'(bus.cpu_addr);
    assign w_cnt_nxt  = r_cnt + 1'b1;

    // w_cov: region applies to this access regardless of R/W/X; w_ok: it also grants it.
    for (genvar g = 0; g < MPU_REGIONS; g++) begin : g_rgn
        logic [31:0] w_pc_lo, w_pc_hi, w_lo, w_hi, w_perm;
        assign w_pc_lo  = r_tab[ENTRY_WORDS*g + 0];
        assign w_pc_hi  = r_tab[ENTRY_WORDS*g + 1];
        assign w_lo     = r_tab[ENTRY_WORDS*g + 2];
        assign w_hi     = r_tab[ENTRY_WORDS*g + 3];
        assign w_perm   = r_tab[ENTRY_WORDS*g + 4];
        assign w_cov[g] = w_perm[31] && (w_lo <= r_addr) && (r_addr <= w_hi) &&
                          (r_instr || ((w_pc_lo <= r_pc) && (r_pc <= w_pc_hi)));
        assign w_ok[g]  = w_cov[g] && (r_instr ? w_perm[2] :
                                       ((|r_wstrb) ? w_perm[1] : w_perm[0]));
    end

    assign w_match = |w_ok;
    assign w_cover = |w_cov;
    assign w_ftype = !w_cover ? 2'd0 : r_instr ? 2'd3 : (|r_wstrb) ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_LOAD_ADDR;
            r_cnt         <= '0;
            for (int unsigned i = 0; i < NWORDS; i++) r_tab[i] <= '0;
            r_busy        <= 1'b1;
            r_ready       <= 1'b0;
            r_rdata       <= '0;
            r_wen         <= '0;
            r_maddr       <= BASE_W;
            r_mwdata      <= '0;
            r_instr       <= 1'b0;
            r_pc          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_reload_pend <= 1'b0;
            r_irq         <= 1'b0;
            r_faddr       <= '0;
            r_fpc         <= '0;
            r_ftype       <= '0;
            r_over        <= 1'b0;
        end else begin
            if (reload && r_state != S_IDLE) r_reload_pend <= 1'b1;
            // Ack first so that a fault on the same edge overrides it below.
            if (irq_ack) begin
                r_irq  <= 1'b0;
                r_over <= 1'b0;
            end
            case (r_state)
                S_LOAD_ADDR: begin
                    r_maddr <= BASE_W + (ADDR_WIDTH-2)'(r_cnt);
                    r_state <= S_LOAD_DATA;
                end
                // mem_addr already holds BASE+cnt one cycle earlier, so mem_rdata is valid here.
                S_LOAD_DATA: begin
                    r_tab[r_cnt] <= bus.mem_rdata;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_maddr <= BASE_W;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                        r_maddr <= BASE_W + (ADDR_WIDTH-2)'(w_cnt_nxt);
                        r_state <= S_LOAD_ADDR;
                    end
                end
                S_IDLE: begin
                    if (reload || r_reload_pend) begin
                        r_reload_pend <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                        r_maddr       <= BASE_W;
                        r_state       <= S_LOAD_ADDR;
                    end else if (bus.cpu_valid && !r_ready && (w_cpu_addr < LIMIT)) begin
                        r_instr <= bus.cpu_instr;
                        r_pc    <= bus.cpu_pc;
                        r_addr  <= w_cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_wstrb <= bus.cpu_wstrb;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_maddr  <= r_addr[ADDR_WIDTH-1:2];
                        r_wen    <= r_wstrb;
                        r_mwdata <= r_wdata;
                        r_state  <= S_ACCESS;
                    end else begin
                        r_rdata <= '0;
                        r_ready <= 1'b1;
                        r_irq   <= 1'b1;
                        r_faddr <= r_addr;
                        r_fpc   <= r_pc;
                        r_ftype <= w_ftype;
                        if (r_irq) r_over <= 1'b1;
                        r_state <= S_FAULT;
                    end
                end
                S_ACCESS: begin
                    r_wen   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wstrb == 4'd0) r_rdata <= bus.mem_rdata;
                    r_ready <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE, S_FAULT: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = r_ready;
    assign bus.cpu_rdata = r_rdata;
    assign bus.mem_wen   = r_wen;
    assign bus.mem_addr  = r_maddr;
    assign bus.mem_wdata = r_mwdata;
    assign busy          = r_busy;
    assign irq           = r_irq;
    assign fault_addr    = r_faddr;
    assign fault_pc      = r_fpc;
    assign fault_type    = r_ftype;
    assign fault_overrun = r_over;
endmodule

// File: tb/tb_mem_mpu_region.sv
// Bench for mem_mpu_region: SRAM model, rule-level permission model, directed and random accesses.
module tb_mem_mpu_region;
    localparam int AW = 22;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        reload = 1'b0;
    logic        irq_ack = 1'b0;
    logic        busy, irq, fault_overrun;
    logic [31:0] fault_addr, fault_pc;
    logic [1:0]  fault_type;

    mem_mpu_region_if #(.ADDR_WIDTH(AW)) bus ();

    mem_mpu_region #(
        .MEM_WORDS(1024), .ADDR_WIDTH(AW), .MPU_REGIONS(4),
        .MPU_BASE_WORD(768), .ENTRY_WORDS(5)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .reload(reload), .irq_ack(irq_ack),
        .busy(busy), .irq(irq), .fault_addr(fault_addr), .fault_pc(fault_pc),
        .fault_type(fault_type), .fault_overrun(fault_overrun)
    );

    always #5 clk = ~clk;

    // SRAM with registered read; a back-door write port lets the bench preload it.
    logic [31:0] sram [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) sram[bd_addr] <= bd_data;
        for (int k = 0; k < 4; k++)
            if (bus.mem_wen[k]) sram[bus.mem_addr[9:0]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        bus.mem_rdata <= sram[bus.mem_addr[9:0]];
    end

    typedef struct {
        logic [31:0] pc_lo, pc_hi, lo, hi, perm;
    } rgn_t;

    rgn_t        sram_tab [4];
    rgn_t        act_tab [4];
    logic [31:0] exp_mem [1024];
    bit          m_irq, m_over;
    logic [31:0] m_faddr, m_fpc, m_rdata;
    logic [1:0]  m_ftype;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = 10'(w); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        exp_mem[w] = d;
    endtask

    task automatic set_entry(input int i, input logic [31:0] pl, ph, lo, hi, perm);
        poke(768 + 5*i + 0, pl);
        poke(768 + 5*i + 1, ph);
        poke(768 + 5*i + 2, lo);
        poke(768 + 5*i + 3, hi);
        poke(768 + 5*i + 4, perm);
        sram_tab[i].pc_lo = pl; sram_tab[i].pc_hi = ph;
        sram_tab[i].lo = lo; sram_tab[i].hi = hi; sram_tab[i].perm = perm;
    endtask

    // Waits (bounded) for busy, then counts cycles until it falls; the table is then live.
    task automatic count_busy(input string tag);
        int w = 0;
        int n = 0;
        while (!busy && w < 10) begin @(negedge clk); w++; end
        while (busy && n < 200) begin @(negedge clk); n++; end
        check_eq(tag, n, 40);
        for (int i = 0; i < 4; i++) act_tab[i] = sram_tab[i];
    endtask

    // Access allowed if any valid region covering the address (and PC, for data) grants
    // the needed right; fault type 0 when no such region covers it at all.
    function automatic void judge(input bit instr, input logic [31:0] pc, addr,
                                  input logic [3:0] wstrb, output bit ok, output logic [1:0] ft);
        bit covered = 0;
        int need = instr ? 2 : ((wstrb != 0) ? 1 : 0);
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (act_tab[i].perm[31] && addr >= act_tab[i].lo && addr <= act_tab[i].hi &&
                (instr || (pc >= act_tab[i].pc_lo && pc <= act_tab[i].pc_hi))) begin
                covered = 1;
                if (act_tab[i].perm[need]) ok = 1;
            end
        end
        ft = !covered ? 2'd0 : 2'(need == 2 ? 3 : need + 1);
    endfunction

    task automatic do_access(input bit instr, input logic [31:0] pc, addr, wdata,
                             input logic [3:0] wstrb, input bit ack_mid, input bit reload_mid);
        bit          ok, in_range, got;
        logic [1:0]  ft;
        int          n, wen_cnt, w;
        logic [19:0] wen_addr;
        logic [3:0]  wen_val;
        in_range = (addr < 32'h1000);
        w = int'(addr[11:2]);
        ok = 0; ft = 0;
        if (in_range) judge(instr, pc, addr, wstrb, ok, ft);
        bus.cpu_valid = 1'b1; bus.cpu_instr = instr; bus.cpu_pc = pc;
        bus.cpu_addr = addr[AW-1:0]; bus.cpu_wdata = wdata; bus.cpu_wstrb = wstrb;
        n = 0; got = 0; wen_cnt = 0; wen_addr = '0; wen_val = '0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (bus.mem_wen != 4'd0) begin
                wen_cnt++; wen_addr = bus.mem_addr; wen_val = bus.mem_wen;
            end
            if (bus.cpu_ready) got = 1;
            irq_ack = ack_mid && n == 1;
            reload  = reload_mid && n == 2;
        end
        bus.cpu_valid = 1'b0; irq_ack = 1'b0; reload = 1'b0;
        if (!in_range) begin
            check_eq("oor_no_ready", 32'(got), 0);
            return;
        end
        if (ok) begin
            if (ack_mid) begin m_irq = 0; m_over = 0; end
            if (wstrb == 0) m_rdata = exp_mem[w];
            for (int b = 0; b < 4; b++) if (wstrb[b]) exp_mem[w][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            m_over  = m_over | m_irq;
            m_irq   = 1; m_faddr = addr; m_fpc = pc; m_ftype = ft; m_rdata = 0;
        end
        check_eq("ready_seen", 32'(got), 1);
        check_eq("latency", n, ok ? 4 : 2);
        check_eq("rdata", bus.cpu_rdata, m_rdata);
        check_eq("wen_cycles", wen_cnt, (ok && wstrb != 0) ? 1 : 0);
        if (ok && wstrb != 0) begin
            check_eq("wen_addr", 32'(wen_addr), 32'(addr[21:2]));
            check_eq("wen_val", 32'(wen_val), 32'(wstrb));
        end
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("overrun", 32'(fault_overrun), 32'(m_over));
        check_eq("fault_addr", fault_addr, m_faddr);
        check_eq("fault_pc", fault_pc, m_fpc);
        check_eq("fault_type", 32'(fault_type), 32'(m_ftype));
        @(negedge clk);
        check_eq("ready_pulse_end", 32'(bus.cpu_ready), 0);
        check_eq("sram_word", sram[w], exp_mem[w]);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        m_irq = 0; m_over = 0;
        check_eq("ack_irq", 32'(irq), 0);
        check_eq("ack_overrun", 32'(fault_overrun), 0);
    endtask

    task automatic model_reset();
        m_irq = 0; m_over = 0; m_faddr = '0; m_fpc = '0; m_ftype = '0; m_rdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        check_eq({tag, "_ready"}, 32'(bus.cpu_ready), 0);
        check_eq({tag, "_rdata"}, bus.cpu_rdata, 0);
        check_eq({tag, "_wen"}, 32'(bus.mem_wen), 0);
        check_eq({tag, "_maddr"}, 32'(bus.mem_addr), 768);
        check_eq({tag, "_mwdata"}, bus.mem_wdata, 0);
        check_eq({tag, "_irq"}, 32'(irq), 0);
        check_eq({tag, "_faddr"}, fault_addr, 0);
        check_eq({tag, "_fpc"}, fault_pc, 0);
        check_eq({tag, "_ftype"}, 32'(fault_type), 0);
        check_eq({tag, "_over"}, 32'(fault_overrun), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0; bus.cpu_pc = '0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 768; i++) poke(i, $urandom());
        set_entry(0, 32'h0,   32'hFFF, 32'h000, 32'h7FF, 32'h8000_0007);
        set_entry(1, 32'h200, 32'h2FF, 32'h800, 32'h8FF, 32'h8000_0003);
        set_entry(2, 32'h0,   32'hFFF, 32'hA00, 32'hAFF, 32'h8000_0001);
        set_entry(3, 32'h0,   32'hFFF, 32'h900, 32'h9FF, 32'h8000_0003);
        check_reset_outputs("rst");
        resetn = 1'b1;
        count_busy("load_after_reset");

        do_access(1, 32'h100, 32'h100, 32'h0, 4'h0, 0, 0);
        do_access(0, 32'h210, 32'h804, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_access(0, 32'h300, 32'h804, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_access(0, 32'h010, 32'hA10, 32'h1234_5678, 4'hF, 0, 0);
        do_access(1, 32'h900, 32'h900, 32'h0, 4'h0, 1, 0);
        pulse_ack();

        set_entry(2, 32'h0, 32'hFFF, 32'hA00, 32'hAFF, 32'h8000_0003);
        do_access(0, 32'h040, 32'h100, 32'h0, 4'h0, 0, 1);
        count_busy("reload_busy");
        do_access(0, 32'h010, 32'hA10, 32'hCAFE_F00D, 4'h3, 0, 0);
        do_access(1, 32'h900, 32'h900, 32'h0, 4'h0, 0, 0);

        // Reset while the read sits in WAIT: no ready may appear, outputs return to reset values.
        bus.cpu_valid = 1'b1; bus.cpu_instr = 1'b0; bus.cpu_pc = 32'h40;
        bus.cpu_addr = 22'h100; bus.cpu_wstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("pre_reset_no_ready", 32'(bus.cpu_ready), 0);
        end
        resetn = 1'b0;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        count_busy("load_after_midrst");

        do_access(0, 32'h0, 32'h1000, 32'h0, 4'h0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] lo, pl, perm;
            lo = 32'($urandom_range(0, 32'h3F0));
            pl = 32'($urandom_range(0, 32'h300));
            perm = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) perm[31] = 1'b1;
            set_entry(i, pl, pl + 32'($urandom_range(0, 32'h1FF)), lo,
                      lo + 32'($urandom_range(0, 32'h1FF)), perm);
        end
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        count_busy("random_reload");
        for (int t = 0; t < 80; t++) begin
            bit          instr;
            logic [31:0] addr;
            logic [3:0]  ws;
            int          sel;
            instr = ($urandom_range(0, 3) == 0);
            addr  = ($urandom_range(0, 15) == 0) ? 32'h1000 + 32'($urandom_range(0, 32'hFFFF))
                                                 : 32'($urandom_range(0, 32'h3FF));
            sel   = $urandom_range(0, 3);
            ws    = instr ? 4'h0 : (sel < 2) ? 4'h0 : (sel == 2) ? 4'hF : 4'($urandom_range(0, 15));
            do_access(instr, 32'($urandom_range(0, 32'h4FF)), addr, $urandom(), ws, 0, 0);
            if ($urandom_range(0, 7) == 0) pulse_ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
